// File: rtl/rv_pipe_pkg.sv
// Shared pipeline type codes, B-type funct3 values and
// forward-select bit positions for the 5-stage RISC-V core.
package rv_pipe_pkg;

  typedef enum logic [2:0] {
    T_R       = 3'b000,
    T_S       = 3'b001,
    T_U       = 3'b010,
    T_I_LOGIC = 3'b011,
    T_J       = 3'b100,
    T_I_LOAD  = 3'b101,
    T_I_JUMP  = 3'b110,
    T_B       = 3'b111
  } pipe_type_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FW_EX_MEM = 1;
  localparam int FW_MEM_WB = 0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } bru_state_e;

  function automatic logic [1:0] sat2_next(
    input logic [1:0] c,
    input logic       up
  );
    if (up)
      return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with one
// combinational lookup port and one registered update port.
module bht_2bit
  import rv_pipe_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] lookup_idx,
  output logic          lookup_taken,
  input  logic          upd_en,
  input  logic [IW-1:0] upd_idx,
  input  logic          upd_taken
);

  logic [1:0] ctr_q [ENTRIES];

  // Reads the stored value, so a same-cycle update is not visible
  assign lookup_taken = ctr_q[lookup_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= sat2_next(ctr_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: compares, targets, redirect,
// flush window, BHT ownership and performance counters.
module branch_resolve_unit
  import rv_pipe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  input  logic            ex_valid,
  input  logic [2:0]      ex_type,
  input  logic [2:0]      ex_func,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  input  logic [1:0]      fw_sel_rs1,
  input  logic [1:0]      fw_sel_rs2,
  input  logic [XLEN-1:0] ex_mem_aluout,
  input  logic [XLEN-1:0] mem_wb_aluout,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int FC_W =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_e state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            rv_d;
  logic [XLEN-1:0] rpc_d;

  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] br_tgt, jalr_sum, jalr_tgt, fall_pc;
  logic            is_b, is_jal, is_jalr;
  logic            acc, cond, dec;
  logic [XLEN-1:0] dec_pc;
  logic            eq, slt, ult;

  // EX_MEM has priority when both forward bits are set
  assign op_a = fw_sel_rs1[FW_EX_MEM] ? ex_mem_aluout :
                fw_sel_rs1[FW_MEM_WB] ? mem_wb_aluout :
                ex_rs1;
  assign op_b = fw_sel_rs2[FW_EX_MEM] ? ex_mem_aluout :
                fw_sel_rs2[FW_MEM_WB] ? mem_wb_aluout :
                ex_rs2;

  assign eq  = (op_a == op_b);
  assign slt = ($signed(op_a) < $signed(op_b));
  assign ult = (op_a < op_b);

  always_comb begin
    cond = 1'b0;
    unique case (ex_func)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = slt;
      F3_BGE:  cond = !slt;
      F3_BLTU: cond = ult;
      F3_BGEU: cond = !ult;
      default: cond = 1'b0;
    endcase
  end

  assign is_b    = (ex_type == T_B);
  assign is_jal  = (ex_type == T_J);
  assign is_jalr = (ex_type == T_I_JUMP);

  assign br_tgt   = ex_pc + ex_imm;
  assign jalr_sum = op_a + ex_imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign fall_pc  = ex_pc + XLEN'(4);

  assign acc = ex_valid && (state_q == S_IDLE);

  always_comb begin
    dec    = 1'b0;
    dec_pc = fall_pc;
    if (acc) begin
      unique case (1'b1)
        is_b: begin
          dec    = (cond != ex_pred_taken);
          dec_pc = cond ? br_tgt : fall_pc;
        end
        is_jal: begin
          dec    = 1'b1;
          dec_pc = br_tgt;
        end
        is_jalr: begin
          dec    = 1'b1;
          dec_pc = jalr_tgt;
        end
        default: dec = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rv_d    = 1'b0;
    rpc_d   = redirect_pc;
    unique case (state_q)
      S_IDLE: begin
        if (dec) begin
          state_d = S_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          rv_d    = 1'b1;
          rpc_d   = dec_pc;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0)
          state_d = S_IDLE;
        else
          fcnt_d = fcnt_q - FC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      fcnt_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
    end
  end

  assign flush = (state_q == S_FLUSH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (acc && is_b && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (dec && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_idx   (lookup_pc[IW+1:2]),
    .lookup_taken (lookup_taken),
    .upd_en       (acc && is_b),
    .upd_idx      (ex_pc[IW+1:2]),
    .upd_taken    (cond)
  );

  logic unused_pc_bits;
  assign unused_pc_bits =
    ^{lookup_pc[XLEN-1:IW+2], lookup_pc[1:0]};

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage control-flow resolver for the 5-stage RISC-V pipeline, parametrised in XLEN and predictor depth.
- Evaluates B/JAL/JALR with forwarded operands and signed/unsigned compares, and checks the outcome against the carried prediction.
- Drives a registered redirect plus a multi-cycle flush window.
- Owns a BHT of 2-bit counters, looked up from ID and updated from EX, and saturating performance counters.

Parameters:
XLEN, 32, datapath/PC width
BHT_ENTRIES, 16, number of 2-bit counters (power of 2, >=2)
FLUSH_CYCLES, 2, cycles flush is held per redirect (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lookup_pc  in  XLEN  PC of instruction in ID, for BHT lookup
lookup_taken  out  1  BHT prediction for lookup_pc (combinational)
ex_valid  in  1  EX holds a valid instruction
ex_type  in  3  pipeline type code: B=111, I_jump(JALR)=110, J(JAL)=100, others ignored
ex_func  in  3  funct3 for B-type
ex_pc  in  XLEN  PC of EX instruction
ex_imm  in  XLEN  sign-extended immediate
ex_rs1  in  XLEN  register-file rs1 value
ex_rs2  in  XLEN  register-file rs2 value
ex_pred_taken  in  1  prediction carried from ID
fw_sel_rs1  in  2  bit1=EX_MEM, bit0=MEM_WB forward for rs1
fw_sel_rs2  in  2  same for rs2
ex_mem_aluout  in  XLEN  EX/MEM forward value
mem_wb_aluout  in  XLEN  MEM/WB forward value
redirect_valid  out  1  one-cycle registered redirect request
redirect_pc  out  XLEN  fetch target when redirect_valid
flush  out  1  kill IF/ID/EX wrong-path instructions
branch_cnt  out  CNT_W  resolved B-type count
mispredict_cnt  out  CNT_W  redirect count

Behaviour:
- Reset (rst_n=0 at clk edge):
  - redirect_valid=0, redirect_pc=0, flush=0, FSM=IDLE.
  - Both counters=0.
  - All BHT entries=2'b01 (weakly not-taken).
- Operand select, per operand: sel bit1 -> ex_mem_aluout; else bit0 -> mem_wb_aluout; else register value. 2'b11 resolves to EX_MEM.
- Condition, by func:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt over full XLEN; 111 unsigned ge over full XLEN.
  - 010/011 not-taken.
- Targets, all modulo 2^XLEN:
  - B and JAL: ex_pc+ex_imm.
  - JALR: (rs1+ex_imm) with bit0 cleared.
  - Fall-through: ex_pc+4.
- Accepted = ex_valid && FSM==IDLE. Wrong-path instructions during a flush are ignored entirely: no redirect, no BHT update, no counts.
- Redirect decision for an accepted instruction:
  - B: redirect iff actual_taken != ex_pred_taken. redirect_pc = actual_taken ? target : fall-through.
  - JAL/JALR: always redirect to target.
- FSM, states IDLE, FLUSH:
  - IDLE + redirect decision -> next cycle: redirect_valid=1 for exactly one cycle, flush=1, FSM=FLUSH, counter loaded FLUSH_CYCLES-1.
  - FLUSH: flush=1, counter decrements; at 0 -> IDLE with flush=0.
  - FLUSH_CYCLES=1: return to IDLE right after the redirect cycle.
  - Latency: decision in cycle N, redirect/flush visible in cycle N+1.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - Prediction = counter MSB.
  - Updated on each accepted B: increment if taken, decrement if not, saturating at 00/11.
  - Same-cycle lookup and update of the same index returns the pre-update value.
- Counters:
  - branch_cnt +1 per accepted B.
  - mispredict_cnt +1 per redirect decision.
  - Both saturate at all-ones (no wrap).
- Reset mid-flush: return to IDLE the next edge, outputs to reset values.

Decomposition:
- Shared package rv_pipe_pkg: type codes (R/S/B/J/U/I_jump/I_logic/I_load), B funct3 constants, forward-select bit positions.
- One sub-module, bht_2bit: BHT_ENTRIES array, lookup port, update port, reset init.
- Compare/target logic and FSM stay in the top.

Test Plan:
- BEQ, rs1=rs2=5, pred=0, ex_pc=0x100, imm=0x20 -> cycle+1: redirect_valid=1, redirect_pc=0x120, flush high for 2 cycles; mispredict_cnt=1.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken (signed), no redirect. BLTU with the same operands and pred=1 -> not-taken, redirect_pc=ex_pc+4.
- JALR rs1 forwarded via fw_sel_rs1=2'b11: ex_mem_aluout=0x201, mem_wb_aluout=0x400, imm=4 -> redirect_pc=0x204 (EX_MEM wins, bit0 cleared).
- Valid JAL arriving during FLUSH -> no second redirect, counters unchanged; after flush ends, the next JAL redirects normally.
- Same index taken four times -> counter saturates at 11, lookup_taken=1. One not-taken -> 10, still predicts taken. Same-cycle lookup during update returns the old value.
- rst_n low during the FLUSH cycle -> next edge flush=0, redirect_valid=0, counters=0, lookup_taken=0 for all indices.
